// File: rtl/smg_scan_control_module_if.sv
// Data/display bundle between the value source and the seven-segment scan controller.
interface smg_scan_control_module_if #(
  parameter int unsigned DIGITS = 8
);
  logic [4*DIGITS-1:0] Data_In;
  logic                Data_Valid;
  logic                LZ_En;
  logic [3:0]          Number_Data;
  logic [DIGITS-1:0]   Scan_Sig;
  logic                Frame_Done;

  modport master (
    output Data_In, Data_Valid, LZ_En,
    input  Number_Data, Scan_Sig, Frame_Done
  );

  modport slave (
    input  Data_In, Data_Valid, LZ_En,
    output Number_Data, Scan_Sig, Frame_Done
  );
endinterface

// File: rtl/smg_scan_control_module.sv
// Multiplexed hex scan of a 4*DIGITS-bit word with frame-aligned updates and
// leading-zero blanking; Scan_Sig is delayed one extra cycle to meet the encoder output.
module smg_scan_control_module #(
  parameter int unsigned T_DIGIT = 50000,
  parameter int unsigned DIGITS  = 8
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  smg_scan_control_module_if.slave   bus
);

  localparam int unsigned PW = (T_DIGIT > 1) ? $clog2(T_DIGIT) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW = 4 * DIGITS;

  logic [PW-1:0]     prescaler;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_d;
  logic              blank_d;
  logic [DW-1:0]     display;
  logic [DW-1:0]     pending;
  logic              pend_flag;

  logic              tick_c;
  logic              frame_c;
  logic              blank_c;
  logic [3:0]        nibble_c;
  logic [DIGITS-1:0] zero_from_c;

  assign tick_c  = (prescaler == PW'(T_DIGIT - 1));
  assign frame_c = tick_c && (idx == IW'(DIGITS - 1));

  // zero_from_c[i]: display nibbles i..DIGITS-1 are all zero
  always_comb begin
    zero_from_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      zero_from_c[i] = ((display >> (4 * i)) == '0);
    end
  end

  // Nibble and blanking decision for the current slot
  always_comb begin
    nibble_c = 4'h0;
    blank_c  = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IW'(i)) begin
        nibble_c = display[4*i +: 4];
        blank_c  = bus.LZ_En && (i != 0) && zero_from_c[i];
      end
    end
  end

  // Digit timing: prescaler and slot index
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= tick_c ? '0 : prescaler + PW'(1);
      if (tick_c) begin
        idx <= frame_c ? '0 : idx + IW'(1);
      end
    end
  end

  // Double-buffered display word; a strobe on the boundary tick bypasses pending
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      display        <= '0;
      pending        <= '0;
      pend_flag      <= 1'b0;
      bus.Frame_Done <= 1'b0;
    end else begin
      bus.Frame_Done <= frame_c;
      if (frame_c) begin
        pend_flag <= 1'b0;
        if (bus.Data_Valid) begin
          display <= bus.Data_In;
        end else if (pend_flag) begin
          display <= pending;
        end
      end else if (bus.Data_Valid) begin
        pending   <= bus.Data_In;
        pend_flag <= 1'b1;
      end
    end
  end

  // Two-stage output pipeline: nibble first, enables one cycle later
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bus.Number_Data <= 4'h0;
      idx_d           <= '0;
      blank_d         <= 1'b1;
      bus.Scan_Sig    <= '1;
    end else begin
      bus.Number_Data <= nibble_c;
      idx_d           <= idx;
      blank_d         <= blank_c;
      bus.Scan_Sig    <= blank_d ? '1 : ~(DIGITS'(1) << idx_d);
    end
  end

endmodule

// File: doc/smg_scan_control_module.md
Name: smg_scan_control_module

Overview:
Time-multiplexing scan controller for the 8-digit seven-segment debug display. Holds a 32-bit value such as a PC or register word and selects one hex nibble per digit slot. Drives the 4-bit Number_Data input of the downstream segment encoder. Generates the active-low digit-select Scan_Sig, delayed to line up with the encoder's one-cycle registered output, and applies tear-free frame-boundary updates and optional leading-zero blanking.

Parameters:
T_DIGIT, 50000, CLK cycles each digit is lit (1 ms at 50 MHz); legal range >= 2.
DIGITS, 8, number of digits; Data_In width = 4*DIGITS.

Ports:
CLK  input  1  system clock.
RSTn  input  1  reset, asynchronous, active-low.
Data_In  input  32  value to display; nibble i appears on digit i, digit 0 rightmost.
Data_Valid  input  1  one-cycle load strobe for Data_In.
LZ_En  input  1  1 = blank leading zero digits.
Number_Data  output  4  nibble to the segment encoder (registered).
Scan_Sig  output  8  digit enables, active-low; bit i = digit i (registered).
Frame_Done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async, RSTn=0):
  - Prescaler=0, idx=0, idx_d=0, display=0, pending=0, pend_flag=0.
  - Number_Data=4'h0, Scan_Sig=8'hFF, Frame_Done=0.
  - Reset mid-frame aborts the scan immediately; pending data is discarded.
- Prescaler: counts 0..T_DIGIT-1 and wraps. tick = (prescaler == T_DIGIT-1).
- Digit index idx: increments on tick; wraps DIGITS-1 -> 0.
- Frame boundary: the tick where idx == DIGITS-1. In that cycle:
  - Frame_Done=1 (registered, visible the following cycle for exactly one cycle).
  - display <= pending if pend_flag; pend_flag <= 0.
- Data_Valid:
  - Captures Data_In into pending and sets pend_flag.
  - Repeated strobes within a frame: last one wins.
  - Display never changes mid-frame.
- Simultaneous Data_Valid and frame boundary: Data_In loads directly into display, pend_flag cleared, older pending value dropped.
- Pipeline, updated every cycle:
  - Stage 1: Number_Data <= display[4*idx +: 4]; idx_d <= idx; blank_d <= blank(idx).
  - Stage 2: Scan_Sig <= blank_d ? 8'hFF : ~(8'b1 << idx_d).
  - Net latency: Number_Data trails idx by 1 cycle. Scan_Sig trails by 2 cycles, matching the encoder's SMG_Data, which is Number_Data + 1 cycle.
  - Consequence: each enable pattern aligns with its segment pattern.
- blank(i) = LZ_En && (i != 0) && (display nibbles i..DIGITS-1 all zero). Digit 0 is always shown. Zeros below the highest nonzero nibble are always shown.
- LZ_En is sampled every cycle, not frame-latched.
- Exactly one Scan_Sig bit is low when the digit is unblanked; all bits are high when blanked or in reset.
- No combinational paths from inputs to outputs.

Test Plan:
1. Reset (T_DIGIT=4): hold RSTn=0, clock running -> Number_Data=0, Scan_Sig=FF, Frame_Done=0. Release -> Scan_Sig=FE on 2nd cycle after release.
2. Load and scan order: Data_In=32'h1234ABCD strobed, LZ_En=0.
   - Display unchanged until the Frame_Done pulse.
   - Next frame: Number_Data = D,C,B,A,4,3,2,1, each held 4 cycles.
   - Scan_Sig = FE,FD,FB,F7,EF,DF,BF,7F, each starting 1 cycle after its nibble.
   - Frame_Done high exactly 1 cycle per 32 cycles.
3. Leading-zero blanking: Data_In=32'h00000305, LZ_En=1.
   - Digits 7..3: Scan_Sig=FF.
   - Digit 2: nibble 3 with FB.
   - Digit 1: nibble 0 with FD (not blanked).
   - Digit 0: nibble 5 with FE.
   - LZ_En=0 -> all eight digits enabled.
4. All-zero data with LZ_En=1 -> only digit 0 enabled (FE, nibble 0); FF for all other slots.
5. Update handshake:
   - Strobe 32'h11111111 then 32'h22222222 mid-frame -> current frame unchanged; next frame shows all 2s.
   - Strobe coinciding with the boundary tick -> that value appears directly in the next frame.
6. Reset mid-frame: deassert then reassert RSTn while idx=5 with pending data -> Scan_Sig=FF asynchronously. After release, the scan restarts at digit 0 with display=0 and the pending data lost.
